time_entry_loader: RTL and testbench
====================================

Name: time_entry_loader

Overview:
- Keypad-side writer for the microwave's BCD down-counter chain (min_ones : sec_tens : sec_ones).
- Collects decimal keys, shifts them in from the right, and normalises seconds-tens values above 5.
- Presents the digits on the counters' data buses and pulses an active-low load strobe.
- Then enables counting until the chain reports zero or the user cancels.

Parameters:
- MAX_DIGITS, 3, maximum keys accepted per entry (legal 1..3); further keys are ignored.
- DIGIT_W, 4, BCD digit width; fixed at 4, parameterised for the package only.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  asynchronous, active-high reset.
- key_valid  in  1  one-cycle strobe; key_digit is valid.
- key_digit  in  4  key code; 0-9 are digits, 10-15 are ignored.
- start  in  1  one-cycle start request.
- cancel  in  1  one-cycle cancel/clear request.
- timer_zero  in  1  level from the counter chain; all digits have reached 0.
- min_ones  out  4  BCD minutes digit to the minutes counter data input.
- sec_tens  out  4  BCD seconds-tens digit to the mod-6 counter data input.
- sec_ones  out  4  BCD seconds-ones digit to the mod-10 counter data input.
- loadn  out  1  active-low parallel-load strobe to all three counters.
- run  out  1  count enable to the counter chain.
- busy  out  1  high in LOAD and RUN.

Behaviour:
- Reset (async, clr=1): state IDLE; all digits 0; digit count 0; loadn=1; run=0; busy=0.
- States and transitions:
  - IDLE: a valid key with code 0-9 shifts in and moves to ENTRY.
  - ENTRY: accepts keys until the count reaches MAX_DIGITS; start moves to NORM.
  - NORM: one cycle, then LOAD.
  - LOAD: one cycle, then RUN.
  - RUN: leaves on timer_zero or cancel.
- Shift rule for an accepted key (code ≤ 9, count < MAX_DIGITS):
  - min_ones ← sec_tens; sec_tens ← sec_ones; sec_ones ← key; count+1.
  - The digit 0 counts as a key, including as the first key.
- Ignored inputs, with no state change:
  - Keys with code > 9 in any state.
  - Keys once count == MAX_DIGITS.
  - All keys in NORM, LOAD and RUN.
- start in IDLE is ignored.
- start in ENTRY when all digits are 0: return to IDLE, count cleared, no load.
- NORM (one cycle), normalisation when sec_tens > 5:
  - If min_ones < 9: sec_tens ← sec_tens − 6, min_ones ← min_ones + 1. Example: 0:90 → 1:30.
  - If min_ones == 9: saturate to 9:59.
  - Otherwise digits are unchanged.
- LOAD (one cycle): loadn=0 and run=0, so the counters load on this edge (they load only while their enable is low). Digits hold stable through LOAD.
- RUN:
  - run=1 and loadn=1.
  - Digit outputs hold the loaded value; the counters own the live time.
  - timer_zero=1 → IDLE: run=0 on the next cycle, digits and count cleared.
- cancel:
  - In ENTRY: clear digits and count, go to IDLE.
  - In RUN: run=0 next cycle, clear digits and count, go to IDLE. The counters keep their value until the next load.
  - In NORM or LOAD: abort to IDLE with no loadn pulse, or with the loadn pulse already issued but run never asserted.
- Priority in the same cycle: cancel > start > key_valid. Also timer_zero > start while in RUN; start is ignored in RUN.
- Latency: 3 cycles from the start strobe to run=1 (NORM, LOAD, RUN). loadn is low for exactly 1 cycle, 2 cycles after start.
- clr asserted mid-operation: immediate return to reset values (run drops asynchronously); no spurious loadn pulse when clr is released.
- All outputs are registered.

Decomposition:
- Shared package microwave_pkg holds:
  - state enum (IDLE, ENTRY, NORM, LOAD, RUN);
  - constants BCD_MAX=9 and SEC_TENS_MAX=5;
  - DIGIT_W.
- One sub-module is natural: bcd_time_normalize, a combinational {min_ones, sec_tens} → normalised pair including the 9:59 saturation.
- The FSM and shift register stay in the top module.

Test Plan:
- Keys 1,3,0 then start → loadn low exactly once, 2 cycles after start, with 1:30 on the buses; run=1 from cycle 3 until timer_zero, then all outputs 0.
- Keys 9,0 then start → loaded value normalised to 1:30. Keys 9,9,9 then start → saturated to 9:59.
- Keys 4,5,6,7 and code 12 → 4:56; the 4th key and code 12 are ignored.
- Key 0 only then start → no loadn pulse, returns to IDLE. start in IDLE → no effect.
- Keys 2,0, start, cancel in the LOAD cycle → run never asserts, state IDLE, digits 0. Same cycle start+cancel in ENTRY → cancel wins.
- clr pulsed during RUN → run=0 immediately, digits 0, loadn stays 1 after clr is released. A key during RUN → ignored.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave keypad/timer path.
package microwave_pkg;
  localparam int DIGIT_W      = 4;
  localparam int BCD_MAX      = 9;
  localparam int SEC_TENS_MAX = 5;

  typedef enum logic [2:0] {IDLE, ENTRY, NORM, LOAD, RUN} state_t;
endpackage

// File: rtl/bcd_time_normalize.sv
// Folds a seconds-tens digit above 5 into the minutes digit, saturating at 9:59.
module bcd_time_normalize
  import microwave_pkg::*;
#(
  parameter int DIGIT_W = microwave_pkg::DIGIT_W
) (
  input  logic [DIGIT_W-1:0] min_ones,
  input  logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] norm_min,
  output logic [DIGIT_W-1:0] norm_tens,
  output logic               sat
);
  always_comb begin
    norm_min  = min_ones;
    norm_tens = sec_tens;
    sat       = 1'b0;
    if (sec_tens > DIGIT_W'(SEC_TENS_MAX)) begin
      if (min_ones < DIGIT_W'(BCD_MAX)) begin
        norm_min  = min_ones + DIGIT_W'(1);
        norm_tens = sec_tens - DIGIT_W'(6);
      end else begin
        // no room for a carry: clamp the whole display to 9:59
        norm_tens = DIGIT_W'(SEC_TENS_MAX);
        sat       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/time_entry_loader.sv
// Keypad entry, normalisation and load/run sequencing for the BCD down-counter chain.
module time_entry_loader
  import microwave_pkg::*;
#(
  parameter int MAX_DIGITS = 3,
  parameter int DIGIT_W    = microwave_pkg::DIGIT_W
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               key_valid,
  input  logic [DIGIT_W-1:0] key_digit,
  input  logic               start,
  input  logic               cancel,
  input  logic               timer_zero,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               loadn,
  output logic               run,
  output logic               busy
);
  localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt, ncnt;
  logic [DIGIT_W-1:0] nmo, nst, nso;
  logic [DIGIT_W-1:0] norm_min, norm_tens;
  logic               sat, key_ok, do_clr;

  bcd_time_normalize #(.DIGIT_W(DIGIT_W)) u_norm (
    .min_ones (min_ones),
    .sec_tens (sec_tens),
    .norm_min (norm_min),
    .norm_tens(norm_tens),
    .sat      (sat)
  );

  assign key_ok = key_valid && (key_digit <= DIGIT_W'(BCD_MAX)) && (cnt < CNT_MAX);

  always_comb begin
    nxt    = state;
    nmo    = min_ones;
    nst    = sec_tens;
    nso    = sec_ones;
    ncnt   = cnt;
    do_clr = 1'b0;
    case (state)
      IDLE: begin
        if (cancel) do_clr = 1'b1;
        else if (key_ok) begin
          {nmo, nst, nso} = {sec_tens, sec_ones, key_digit};
          ncnt = cnt + CNT_W'(1);
          nxt  = ENTRY;
        end
      end
      ENTRY: begin
        if (cancel) begin
          do_clr = 1'b1;
          nxt    = IDLE;
        end else if (start) begin
          // an all-zero entry has nothing to count down, so drop it
          if ({min_ones, sec_tens, sec_ones} == '0) begin
            do_clr = 1'b1;
            nxt    = IDLE;
          end else nxt = NORM;
        end else if (key_ok) begin
          {nmo, nst, nso} = {sec_tens, sec_ones, key_digit};
          ncnt = cnt + CNT_W'(1);
        end
      end
      NORM: begin
        if (cancel) begin
          do_clr = 1'b1;
          nxt    = IDLE;
        end else begin
          nmo = norm_min;
          nst = norm_tens;
          if (sat) nso = DIGIT_W'(BCD_MAX);
          nxt = LOAD;
        end
      end
      LOAD: begin
        if (cancel) begin
          do_clr = 1'b1;
          nxt    = IDLE;
        end else nxt = RUN;
      end
      RUN: begin
        if (cancel || timer_zero) begin
          do_clr = 1'b1;
          nxt    = IDLE;
        end
      end
      default: begin
        do_clr = 1'b1;
        nxt    = IDLE;
      end
    endcase
    if (do_clr) begin
      nmo  = '0;
      nst  = '0;
      nso  = '0;
      ncnt = '0;
    end
  end

  // strobes are decoded from the next state so they line up with the state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cnt      <= '0;
      min_ones <= '0;
      sec_tens <= '0;
      sec_ones <= '0;
      loadn    <= 1'b1;
      run      <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= ncnt;
      min_ones <= nmo;
      sec_tens <= nst;
      sec_ones <= nso;
      loadn    <= (nxt != LOAD);
      run      <= (nxt == RUN);
      busy     <= (nxt == LOAD) || (nxt == RUN);
    end
  end
endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader: entry, normalisation, load/run timing, aborts.
module tb_time_entry_loader;
  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       start = 1'b0;
  logic       cancel = 1'b0;
  logic       timer_zero = 1'b0;
  logic [3:0] min_ones, sec_tens, sec_ones;
  logic       loadn, run, busy;

  int n_run  = 0;
  int n_fail = 0;
  int lcnt   = 0;
  int lsnap;

  time_entry_loader #(.MAX_DIGITS(3), .DIGIT_W(4)) dut (
    .clk       (clk),
    .clr       (clr),
    .key_valid (key_valid),
    .key_digit (key_digit),
    .start     (start),
    .cancel    (cancel),
    .timer_zero(timer_zero),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .loadn     (loadn),
    .run       (run),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (!loadn) lcnt++;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [15:0] disp();
    return {4'h0, min_ones, sec_tens, sec_ones};
  endfunction

  // start, then check the NORM/LOAD/RUN timing and the loaded value
  task automatic run_load(input string tag, input logic [15:0] exp);
    lsnap = lcnt;
    pulse_start();
    chk({tag, "_norm_loadn"}, {15'd0, loadn}, 16'd1);
    chk({tag, "_norm_run"}, {15'd0, run}, 16'd0);
    tick();
    chk({tag, "_load_loadn"}, {15'd0, loadn}, 16'd0);
    chk({tag, "_load_run"}, {15'd0, run}, 16'd0);
    chk({tag, "_load_busy"}, {15'd0, busy}, 16'd1);
    chk({tag, "_load_val"}, disp(), exp);
    tick();
    chk({tag, "_run"}, {15'd0, run}, 16'd1);
    chk({tag, "_run_loadn"}, {15'd0, loadn}, 16'd1);
    chk({tag, "_run_val"}, disp(), exp);
  endtask

  task automatic stop_zero(input string tag);
    timer_zero = 1'b1;
    tick();
    timer_zero = 1'b0;
    chk({tag, "_tz_run"}, {15'd0, run}, 16'd0);
    chk({tag, "_tz_busy"}, {15'd0, busy}, 16'd0);
    chk({tag, "_tz_val"}, disp(), 16'h000);
    chk({tag, "_pulses"}, 16'(lcnt - lsnap), 16'd1);
  endtask

  initial begin
    tick();
    chk("rst_val", disp(), 16'h000);
    chk("rst_loadn", {15'd0, loadn}, 16'd1);
    chk("rst_run", {15'd0, run}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    clr = 1'b0;
    tick();

    // 1,3,0 -> 1:30, key during RUN ignored
    press(4'd1); press(4'd3); press(4'd0);
    chk("t1_entry", disp(), 16'h130);
    run_load("t1", 16'h130);
    tick();
    press(4'd5);
    chk("t1_key_in_run", disp(), 16'h130);
    chk("t1_still_run", {15'd0, run}, 16'd1);
    stop_zero("t1");

    // 0:90 -> 1:30
    press(4'd9); press(4'd0);
    chk("t2_entry", disp(), 16'h090);
    run_load("t2", 16'h130);
    stop_zero("t2");

    // 9:99 -> 9:59
    press(4'd9); press(4'd9); press(4'd9);
    run_load("t3", 16'h959);
    stop_zero("t3");

    // fourth key and code 12 ignored
    press(4'd4); press(4'd5); press(4'd6); press(4'd7); press(4'd12);
    chk("t4_entry", disp(), 16'h456);
    run_load("t4", 16'h456);
    stop_zero("t4");

    // leading zero counts as a key
    press(4'd0); press(4'd1); press(4'd2); press(4'd3);
    chk("t4b_zero_first", disp(), 16'h012);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("t4b_cancel_entry", disp(), 16'h000);

    // zero entry and start in IDLE do nothing; then the count restarts from 0
    lsnap = lcnt;
    press(4'd0);
    pulse_start(); tick(); tick();
    chk("t5_zero_pulses", 16'(lcnt - lsnap), 16'd0);
    chk("t5_zero_run", {15'd0, run}, 16'd0);
    chk("t5_zero_busy", {15'd0, busy}, 16'd0);
    pulse_start(); tick(); tick();
    chk("t5_idle_pulses", 16'(lcnt - lsnap), 16'd0);
    chk("t5_idle_busy", {15'd0, busy}, 16'd0);
    press(4'd1); press(4'd2); press(4'd3);
    chk("t5_recount", disp(), 16'h123);
    cancel = 1'b1; tick(); cancel = 1'b0;

    // cancel during LOAD: pulse issued, run never asserts
    lsnap = lcnt;
    press(4'd2); press(4'd0);
    pulse_start();
    tick();
    chk("t6_in_load", {15'd0, loadn}, 16'd0);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("t6_run", {15'd0, run}, 16'd0);
    chk("t6_val", disp(), 16'h000);
    chk("t6_busy", {15'd0, busy}, 16'd0);
    tick(); tick();
    chk("t6_run_late", {15'd0, run}, 16'd0);
    chk("t6_pulses", 16'(lcnt - lsnap), 16'd1);

    // start and cancel together in ENTRY
    lsnap = lcnt;
    press(4'd3);
    start = 1'b1; cancel = 1'b1; tick(); start = 1'b0; cancel = 1'b0;
    chk("t7_val", disp(), 16'h000);
    tick(); tick(); tick();
    chk("t7_pulses", 16'(lcnt - lsnap), 16'd0);
    chk("t7_run", {15'd0, run}, 16'd0);

    // async clear during RUN
    press(4'd1); press(4'd2);
    run_load("t8", 16'h012);
    lsnap = lcnt;
    clr = 1'b1;
    #1;
    chk("t8_clr_run", {15'd0, run}, 16'd0);
    chk("t8_clr_val", disp(), 16'h000);
    tick();
    clr = 1'b0;
    tick(); tick(); tick();
    chk("t8_post_loadn", {15'd0, loadn}, 16'd1);
    chk("t8_post_pulses", 16'(lcnt - lsnap), 16'd0);
    chk("t8_post_busy", {15'd0, busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
